// File: rtl/axis_i2s_rx_ctrl.sv
// axis_i2s_rx_ctrl: I2S receiver with warm-up discard and an AXIS frame FIFO.
// Ports: aclk/resetn, cfg_* control, status_* out, m_axis_* stream, mclk/lrck/sclk/sdin pins.
module axis_i2s_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVF_W      = 16
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             cfg_enable,
  input  logic [1:0]       cfg_rate,
  input  logic [7:0]       cfg_discard,
  output logic [1:0]       status_state,
  output logic [OVF_W-1:0] status_ovf_cnt,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             mclk,
  output logic             lrck,
  output logic             sclk,
  input  logic             sdin
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  state_t           state;
  logic [8:0]       cnt;
  logic [1:0]       rate_q;
  logic [7:0]       disc;
  logic [23:0]      l_sr;
  logic [23:0]      r_sr;
  logic [63:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [OVF_W-1:0] ovf;

  logic       wrap;
  logic       sclk_c;
  logic       lrck_c;
  logic       rise;
  logic [5:0] slot;
  logic [8:0] cnt_nxt;
  logic       push_req;
  logic       pop;
  logic       full;
  logic       push_ok;
  logic [63:0] word;

  // Rate decode: frame length, bit clock tap and slot index
  // all come from the same free-running counter.
  always_comb begin
    wrap   = 1'b0;
    sclk_c = 1'b0;
    lrck_c = 1'b0;
    rise   = 1'b0;
    slot   = '0;
    unique case (rate_q)
      2'd0: begin
        wrap   = (cnt == 9'd511);
        lrck_c = cnt[8];
        sclk_c = cnt[2];
        rise   = (cnt[2:0] == 3'b100);
        slot   = cnt[8:3];
      end
      2'd2: begin
        wrap   = (cnt == 9'd127);
        lrck_c = cnt[6];
        sclk_c = cnt[0];
        rise   = cnt[0];
        slot   = cnt[6:1];
      end
      default: begin
        wrap   = (cnt == 9'd255);
        lrck_c = cnt[7];
        sclk_c = cnt[1];
        rise   = (cnt[1:0] == 2'b10);
        slot   = cnt[7:2];
      end
    endcase
  end

  assign cnt_nxt  = wrap ? '0 : cnt + 9'd1;
  assign word     = {l_sr, 8'd0, r_sr, 8'd0};
  assign push_req = wrap && ((state == ST_RUN) || (state == ST_STOP));
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign full     = (count == FULL_C);
  // A full FIFO still accepts the frame if a beat leaves this cycle.
  assign push_ok  = push_req && (!full || pop);

  // Sequencer and frame counter.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rate_q <= 2'd0;
      disc   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (cfg_enable) begin
            unique case (1'b1)
              cfg_rate == 2'd0: rate_q <= 2'd0;
              cfg_rate == 2'd2: rate_q <= 2'd2;
              default:          rate_q <= 2'd1;
            endcase
            disc  <= cfg_discard;
            state <= (cfg_discard == 8'd0) ? ST_RUN : ST_WARM;
          end
        end
        ST_WARM: begin
          if (!cfg_enable) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nxt;
            if (wrap) begin
              disc <= disc - 8'd1;
              if (disc <= 8'd1) state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt_nxt;
          if (!cfg_enable) state <= ST_STOP;
        end
        ST_STOP: begin
          cnt <= cnt_nxt;
          if (wrap) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Deserialiser: one-bit I2S delay puts the MSB in slot 1 / 33.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      l_sr <= '0;
      r_sr <= '0;
    end else if (rise) begin
      if (slot >= 6'd1 && slot <= 6'd24)
        l_sr <= {l_sr[22:0], sdin};
      if (slot >= 6'd33 && slot <= 6'd56)
        r_sr <= {r_sr[22:0], sdin};
    end
  end

  // Output frame FIFO with saturating overflow count.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok && (ovf != '1))
        ovf <= ovf + OVF_W'(1);
    end
  end

  assign status_state   = state;
  assign status_ovf_cnt = ovf;
  assign m_axis_tvalid  = (count != '0);
  assign m_axis_tlast   = m_axis_tvalid;
  assign m_axis_tdata   = mem[rd_ptr];
  assign mclk           = aclk;
  assign lrck           = lrck_c;
  assign sclk           = sclk_c;

endmodule

// File: tb/tb_axis_i2s_rx_ctrl.sv
// tb_axis_i2s_rx_ctrl: randomized frames against a frame-level queue model.
// Drives the I2S pins from sclk/lrck and scores every AXIS beat.
module tb_axis_i2s_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int OVF_W = 16;

  logic             aclk = 1'b0;
  logic             resetn = 1'b1;
  logic             cfg_enable = 1'b0;
  logic [1:0]       cfg_rate = 2'd0;
  logic [7:0]       cfg_discard = 8'd0;
  logic [1:0]       status_state;
  logic [OVF_W-1:0] status_ovf_cnt;
  logic [63:0]      tdata;
  logic             tvalid;
  logic             tready = 1'b0;
  logic             tlast;
  logic             mclk;
  logic             lrck;
  logic             sclk;
  logic             sdin = 1'b0;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int exp_ovf = 0;
  int slot = 0;
  int frame_idx = 0;
  int cur_discard = 0;
  logic [63:0] q[$];
  logic [23:0] l_w = '0;
  logic [23:0] r_w = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_tvalid = 1'b0;
  logic        prev_tready = 1'b0;
  logic [63:0] prev_tdata = '0;
  logic [63:0] exp_w;

  axis_i2s_rx_ctrl #(.FIFO_DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .cfg_enable    (cfg_enable),
    .cfg_rate      (cfg_rate),
    .cfg_discard   (cfg_discard),
    .status_state  (status_state),
    .status_ovf_cnt(status_ovf_cnt),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .mclk          (mclk),
    .lrck          (lrck),
    .sclk          (sclk),
    .sdin          (sdin)
  );

  always #5 aclk = ~aclk;

  // Pin driver plus frame-level model: every completed frame past
  // the discard count goes into a depth-limited queue or is counted lost.
  initial forever begin
    @(negedge aclk);
    #1;
    if (!resetn) begin
      q.delete();
      exp_ovf = 0;
      slot = 0;
      frame_idx = 0;
      prev_sclk = 1'b0;
      prev_tvalid = 1'b0;
      prev_tready = 1'b0;
    end else begin
      if (prev_tvalid && prev_tready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got %h want none", prev_tdata);
        end else begin
          exp_w = q.pop_front();
          if (prev_tdata !== exp_w) begin
            errors++;
            $display("FAIL beat_data got %h want %h", prev_tdata, exp_w);
          end
        end
        beats++;
      end
      if (prev_tvalid && !prev_tready) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== prev_tdata) begin
          errors++;
          $display("FAIL hold got %b/%h want 1/%h", tvalid, tdata, prev_tdata);
        end
      end
      if (prev_sclk && !sclk && slot == 63) begin
        if (frame_idx >= cur_discard) begin
          if (q.size() < DEPTH) q.push_back({l_w, 8'h00, r_w, 8'h00});
          else if (exp_ovf < (1 << OVF_W) - 1) exp_ovf++;
        end
        frame_idx++;
      end
      if (prev_sclk && !sclk) slot = (slot + 1) % 64;
      if (status_state == 2'd0) begin
        slot = 0;
        frame_idx = 0;
      end
      if (slot == 0) begin
        l_w = 24'($urandom);
        r_w = 24'($urandom);
      end
      if (slot >= 1 && slot <= 24) sdin = l_w[24 - slot];
      else if (slot >= 33 && slot <= 56) sdin = r_w[56 - slot];
      else sdin = 1'($urandom_range(0, 1));
      checks++;
      if (tvalid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL valid got %b want %0d", tvalid, q.size() != 0);
      end
      checks++;
      if (tlast !== tvalid) begin
        errors++;
        $display("FAIL tlast got %b want %b", tlast, tvalid);
      end
      checks++;
      if (status_ovf_cnt !== OVF_W'(exp_ovf)) begin
        errors++;
        $display("FAIL ovf got %0d want %0d", status_ovf_cnt, exp_ovf);
      end
      prev_sclk = sclk;
      prev_tvalid = tvalid;
      prev_tready = tready;
      prev_tdata = tdata;
    end
  end

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if (status_state !== 2'd0 || tvalid !== 1'b0 || tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got %0d/%b/%b want 0/0/0", status_state, tvalid, tlast);
    end
    checks++;
    if (tdata !== 64'd0 || status_ovf_cnt !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%0d want 0/0", tdata, status_ovf_cnt);
    end
    checks++;
    if (sclk !== 1'b0 || lrck !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins got %b/%b want 0/0", sclk, lrck);
    end
    resetn = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if (status_state !== 2'd0 || sclk !== 1'b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %0d/%b/%b want 0/0/0", status_state, sclk, tvalid);
    end
  endtask

  task automatic test_stream(input logic [1:0] rate, input int d, input int nb);
    int n;
    int t;
    int b0;
    n = (rate == 2'd0) ? 512 : (rate == 2'd2) ? 128 : 256;
    cfg_rate = rate;
    cfg_discard = 8'(d);
    cur_discard = d;
    tready = 1'b1;
    @(negedge aclk);
    cfg_enable = 1'b1;
    t = 0;
    while (tvalid !== 1'b1 && t < (d + 2) * n) begin
      @(negedge aclk);
      t++;
    end
    checks++;
    if (t != (d + 1) * n + 1) begin
      errors++;
      $display("FAIL first_beat_latency rate %0d got %0d want %0d", rate, t, (d + 1) * n + 1);
    end
    t = 0;
    while (tvalid === 1'b1 && t < 2 * n) begin
      @(negedge aclk);
      t++;
    end
    while (tvalid !== 1'b1 && t < 2 * n) begin
      @(negedge aclk);
      t++;
    end
    checks++;
    if (t != n) begin
      errors++;
      $display("FAIL beat_spacing rate %0d got %0d want %0d", rate, t, n);
    end
    t = 0;
    while (sclk !== 1'b0 && t < 64) begin @(negedge aclk); t++; end
    while (sclk !== 1'b1 && t < 64) begin @(negedge aclk); t++; end
    t = 0;
    while (sclk === 1'b1 && t < 64) begin @(negedge aclk); t++; end
    while (sclk !== 1'b1 && t < 64) begin @(negedge aclk); t++; end
    checks++;
    if (t != n / 64) begin
      errors++;
      $display("FAIL sclk_period rate %0d got %0d want %0d", rate, t, n / 64);
    end
    t = 0;
    while (lrck !== 1'b0 && t < 2 * n) begin @(negedge aclk); t++; end
    while (lrck !== 1'b1 && t < 2 * n) begin @(negedge aclk); t++; end
    t = 0;
    while (lrck === 1'b1 && t < 2 * n) begin @(negedge aclk); t++; end
    while (lrck !== 1'b1 && t < 2 * n) begin @(negedge aclk); t++; end
    checks++;
    if (t != n) begin
      errors++;
      $display("FAIL lrck_period rate %0d got %0d want %0d", rate, t, n);
    end
    b0 = beats;
    t = 0;
    while (beats < b0 + nb && t < (nb + 2) * n) begin @(negedge aclk); t++; end
    checks++;
    if (beats < b0 + nb) begin
      errors++;
      $display("FAIL beat_count got %0d want %0d", beats - b0, nb);
    end
    repeat ($urandom_range(0, n - 1)) @(negedge aclk);
    cfg_enable = 1'b0;
    t = 0;
    while (status_state !== 2'd0 && t < 2 * n) begin @(negedge aclk); t++; end
    repeat (4) @(negedge aclk);
    checks++;
    if (status_state !== 2'd0 || tvalid !== 1'b0 || sclk !== 1'b0 || lrck !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got %0d/%b/%b/%b want 0/0/0/0", status_state, tvalid, sclk, lrck);
    end
  endtask

  task automatic test_backpressure();
    int t;
    int b0;
    cfg_rate = 2'd2;
    cfg_discard = 8'd0;
    cur_discard = 0;
    tready = 1'b0;
    @(negedge aclk);
    cfg_enable = 1'b1;
    t = 0;
    while (tvalid !== 1'b1 && t < 300) begin @(negedge aclk); t++; end
    checks++;
    if (t != 129) begin
      errors++;
      $display("FAIL no_discard_latency got %0d want 129", t);
    end
    repeat (690 - t) @(negedge aclk);
    cfg_enable = 1'b0;
    t = 0;
    while (status_state !== 2'd0 && t < 300) begin @(negedge aclk); t++; end
    repeat (3) @(negedge aclk);
    checks++;
    if (status_ovf_cnt !== 16'd2 || tvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got ovf %0d valid %b want 2 1", status_ovf_cnt, tvalid);
    end
    b0 = beats;
    tready = 1'b1;
    repeat (8) @(negedge aclk);
    #2;
    checks++;
    if (beats - b0 != 4 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %0d beats want 4", beats - b0);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    cfg_rate = 2'd2;
    cfg_discard = 8'd0;
    cur_discard = 0;
    tready = 1'b0;
    @(negedge aclk);
    cfg_enable = 1'b1;
    t = 0;
    while (q.size() < 2 && t < 600) begin @(negedge aclk); t++; end
    repeat (20) @(negedge aclk);
    checks++;
    if (tvalid !== 1'b1 || status_ovf_cnt === '0) begin
      errors++;
      $display("FAIL pre_reset got valid %b ovf %0d want 1 nonzero", tvalid, status_ovf_cnt);
    end
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (tvalid !== 1'b0 || status_ovf_cnt !== '0 || status_state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got %b/%0d/%0d want 0/0/0", tvalid, status_ovf_cnt, status_state);
    end
    checks++;
    if (tdata !== 64'd0 || sclk !== 1'b0 || lrck !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_pins got %h/%b/%b want 0/0/0", tdata, sclk, lrck);
    end
    cfg_enable = 1'b0;
    tready = 1'b1;
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    repeat (2) @(negedge aclk);
    test_stream(2'd2, 1, 3);
  endtask

  task automatic test_stop();
    int t;
    int b0;
    cfg_rate = 2'd1;
    cfg_discard = 8'd0;
    cur_discard = 0;
    tready = 1'b1;
    @(negedge aclk);
    cfg_enable = 1'b1;
    t = 0;
    while (lrck !== 1'b1 && t < 600) begin @(negedge aclk); t++; end
    while (lrck !== 1'b0 && t < 600) begin @(negedge aclk); t++; end
    repeat (100) @(negedge aclk);
    b0 = beats;
    cfg_enable = 1'b0;
    @(negedge aclk);
    t = 0;
    while (status_state === 2'd3 && t < 400) begin
      t++;
      if (t == 20) cfg_enable = 1'b1;
      @(negedge aclk);
    end
    checks++;
    if (t != 155) begin
      errors++;
      $display("FAIL stop_length got %0d want 155", t);
    end
    checks++;
    if (status_state !== 2'd0 || sclk !== 1'b0 || lrck !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle got %0d/%b/%b want 0/0/0", status_state, sclk, lrck);
    end
    @(negedge aclk);
    checks++;
    if (status_state !== 2'd2) begin
      errors++;
      $display("FAIL restart got %0d want 2", status_state);
    end
    @(negedge aclk);
    #2;
    checks++;
    if (beats != b0 + 1) begin
      errors++;
      $display("FAIL stop_push got %0d want %0d", beats, b0 + 1);
    end
    repeat (300) @(negedge aclk);
    cfg_enable = 1'b0;
    t = 0;
    while (status_state !== 2'd0 && t < 600) begin @(negedge aclk); t++; end
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_warmup_abort();
    int b0;
    cfg_rate = 2'd1;
    cfg_discard = 8'd5;
    cur_discard = 5;
    tready = 1'b1;
    b0 = beats;
    @(negedge aclk);
    cfg_enable = 1'b1;
    repeat (300) @(negedge aclk);
    checks++;
    if (status_state !== 2'd1) begin
      errors++;
      $display("FAIL warmup_state got %0d want 1", status_state);
    end
    cfg_enable = 1'b0;
    @(negedge aclk);
    checks++;
    if (status_state !== 2'd0 || sclk !== 1'b0 || lrck !== 1'b0) begin
      errors++;
      $display("FAIL warmup_abort got %0d/%b/%b want 0/0/0", status_state, sclk, lrck);
    end
    repeat (700) @(negedge aclk);
    checks++;
    if (beats != b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL warmup_beats got %0d want 0", beats - b0);
    end
  endtask

  initial begin
    test_reset();
    test_stream(2'd1, 2, 4);
    test_stream(2'd0, 2, 2);
    test_stream(2'd2, 2, 4);
    test_stream(2'd3, 1, 3);
    test_backpressure();
    test_reset_mid();
    test_stop();
    test_warmup_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_i2s_rx_ctrl.md
Name: axis_i2s_rx_ctrl

Overview:
- Rate-programmable I2S receive controller with AXI-Stream output.
- Generates mclk/sclk/lrck from one clock and deserialises sdin using single-clock enables (no derived clock domains).
- Sequences start-up: discards a programmable number of warm-up frames, then streams stereo frames through a small FIFO.
- Sits between the audio ADC pins and the AXIS audio pipeline; exposes status for a register block.

Parameters:
- FIFO_DEPTH, 4, output frame FIFO entries (power of 2, ≥2).
- OVF_W, 16, width of overflow counter.

Ports:
- aclk  in  1  system clock; also forwarded as mclk.
- resetn  in  1  asynchronous active-low reset.
- cfg_enable  in  1  level; 1 = run receiver.
- cfg_rate  in  2  0: 512 aclk/frame; 1: 256; 2: 128; 3: treated as 1.
- cfg_discard  in  8  frames dropped after start.
- status_state  out  2  0 IDLE, 1 WARMUP, 2 RUN, 3 STOP.
- status_ovf_cnt  out  OVF_W  frames dropped on full FIFO, saturating.
- m_axis_tdata  out  64  {l_data[23:0], 8'd0, r_data[23:0], 8'd0}.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  equals m_axis_tvalid (one beat per frame).
- mclk  out  1  = aclk.
- lrck  out  1  0 = left half, 1 = right half.
- sclk  out  1  bit clock, 64 periods per frame.
- sdin  in  1  serial data.

Behaviour:
- Reset (async): state IDLE, frame counter 0, lrck/sclk 0, FIFO empty, tvalid 0, tdata 0, ovf_cnt 0, discard counter 0.
- Frame counter: 9 bits, increments every aclk outside IDLE, wraps at 512/256/128 per latched rate.
  - lrck = cnt[8]/[7]/[6]; sclk = cnt[2]/[1]/[0].
  - cfg_rate latched only on IDLE→WARMUP; ignored while active.
- Sampling:
  - On the aclk where sclk goes 0→1 (rising edge), sdin is captured; slot index k = 0..63 from the counter bits above sclk.
  - I2S one-bit delay: slots 1..24 → left[23:0], MSB first; slots 33..56 → right[23:0]; other slots ignored.
- Frame complete: the cycle the counter wraps to 0; the assembled word is available that cycle.
- FSM transitions:
  - IDLE: counter held at 0, sclk/lrck low. cfg_enable=1 → WARMUP; discard counter loads cfg_discard. If cfg_discard=0 → RUN directly.
  - WARMUP: each frame complete decrements the discard counter and drops the frame. At 0 → RUN, so the next frame is the first pushed.
  - RUN: each frame complete pushes the word to the FIFO. cfg_enable=0 → STOP.
  - STOP: counter runs to wrap; that final frame is pushed. Then → IDLE with counter 0.
  - cfg_enable=0 in WARMUP → IDLE immediately; counter cleared, no push.
- FIFO and handshake:
  - Push and pop may occur in the same cycle.
  - Push when full: frame dropped, ovf_cnt +1 (saturates at all-ones).
  - If full and the downstream pops in the same cycle, the push succeeds.
  - tdata/tvalid are stable while tvalid=1 and tready=0.
  - FIFO is not flushed by STOP/IDLE; remaining entries drain normally.
- Latency: frame wrap → tvalid at the FIFO output within 1 aclk when the FIFO is empty.
- cfg_enable toggling 1→0→1 within a frame: STOP completes first; IDLE→WARMUP occurs no earlier than the cycle after the STOP→IDLE transition.
- Reset asserted mid-frame: all state cleared immediately; partial frame lost.

Test Plan:
- rate=1, discard=2, tready=1, sdin driven with left=0xA5A5A5, right=0x123456 every frame → first 2 frames absent; beat 1 tdata=0xA5A5A500_12345600, tlast=1; beats spaced 256 aclk.
- rate=0 and rate=2 with the same pattern → sclk period 8/2 aclk, lrck period 512/128, identical tdata; rate=3 behaves as rate=1.
- tready=0 for 6 frames, FIFO_DEPTH=4 → 4 beats held stable, ovf_cnt=2; release tready → exactly 4 beats, oldest first.
- cfg_enable=0 mid-RUN at counter=100 (rate=1) → status_state=3 until wrap; that frame is pushed, then IDLE with sclk/lrck low.
- cfg_discard=0 → first completed frame pushed; cfg_enable dropped in WARMUP (discard=5) → IDLE, no beats.
- resetn pulsed low mid-frame with 2 FIFO entries → tvalid=0 and ovf_cnt=0 asynchronously; restart yields clean frames.
